// File: rtl/pc_stack_pkg.sv
// Shared constants and command priority encoding for the program counter
// with a hardware return-address stack.
package pc_stack_pkg;

    localparam int PC_WIDTH = 16;
    localparam int PC_DEPTH = 8;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_HOLD = 3'd0;
    localparam cmd_t CMD_INC  = 3'd1;
    localparam cmd_t CMD_LOAD = 3'd2;
    localparam cmd_t CMD_CALL = 3'd3;
    localparam cmd_t CMD_RET  = 3'd4;

    // ret > call > load > inc > hold; only the winner acts.
    function automatic cmd_t pick_cmd(input logic load, input logic inc,
                                      input logic call, input logic ret);
        if (ret)       return CMD_RET;
        else if (call) return CMD_CALL;
        else if (load) return CMD_LOAD;
        else if (inc)  return CMD_INC;
        else           return CMD_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the fetch-path decoder and the PC stack.
interface pc_stack_if #(
    parameter int WIDTH = pc_stack_pkg::PC_WIDTH,
    parameter int LW    = $clog2(pc_stack_pkg::PC_DEPTH + 1)
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] top;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, load, inc, call, ret,
        input  out, top, level, empty, full, overflow, underflow
    );

    modport slave (
        input  in, load, inc, call, ret,
        output out, top, level, empty, full, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_lifo.sv
// Return-address LIFO; the parent guarantees push only when not full and
// pop only when not empty. Storage is not cleared on reset.
module pc_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = level_q[AW-1:0];
    assign rd_idx = level_q[AW-1:0] - AW'(1);

    always_comb begin
        level_d = level_q;
        if (push)     level_d = level_q + LW'(1);
        else if (pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) level_q <= '0;
        else       level_q <= level_d;
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_idx] <= wdata;
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_idx];
endmodule

// File: rtl/pc_stack.sv
// Program counter with single-cycle call/return through a return-address
// stack; all state registered, commands resolved by fixed priority.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = PC_DEPTH,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic        clock,
    input  logic        reset,
    pc_stack_if.slave   bus
);
    logic [WIDTH-1:0] out_q;
    logic             overflow_q;
    logic             underflow_q;
    cmd_t             cmd;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] top;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;

    assign cmd  = pick_cmd(bus.load, bus.inc, bus.call, bus.ret);
    assign push = (cmd == CMD_CALL) && !full;
    assign pop  = (cmd == CMD_RET) && !empty;

    pc_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) u_lifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (out_q + WIDTH'(1)),
        .rdata (top),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (cmd)
                CMD_RET: begin
                    if (!empty) out_q <= top;
                    else        underflow_q <= 1'b1;
                end
                CMD_CALL: begin
                    if (!full) out_q <= bus.in;
                    else       overflow_q <= 1'b1;
                end
                CMD_LOAD: out_q <= bus.in;
                CMD_INC:  out_q <= out_q + WIDTH'(1);
                default:  out_q <= out_q;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.top       = top;
    assign bus.level     = level;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_pc_stack.sv
// Directed and random stimulus for pc_stack, checked against a queue-based
// reference model of the PC and its return stack.
module tb_pc_stack;
    localparam int W = 16;
    localparam int D = 8;
    localparam int L = $clog2(D + 1);

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pc_stack_if #(.WIDTH(W), .LW(L)) bus ();

    pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [W-1:0] m_out;
    logic [W-1:0] m_stk[$];
    logic         m_ovf;
    logic         m_unf;

    task automatic model_step(input logic r, input logic ld, input logic ic,
                              input logic cl, input logic rt, input logic [W-1:0] a);
        if (r) begin
            m_out = '0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (rt) begin
            if (m_stk.size() > 0) m_out = m_stk.pop_back();
            else                  m_unf = 1'b1;
        end else if (cl) begin
            if (m_stk.size() < D) begin
                m_stk.push_back(m_out + 16'd1);
                m_out = a;
            end else m_ovf = 1'b1;
        end else if (ld) m_out = a;
        else if (ic)     m_out = m_out + 16'd1;
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] e_top;
        logic [L-1:0] e_lvl;
        e_top = (m_stk.size() > 0) ? m_stk[$] : '0;
        e_lvl = L'(m_stk.size());
        checks++;
        assert (bus.out === m_out) else begin
            errors++; $error("FAIL %s out got %h exp %h", tag, bus.out, m_out);
        end
        checks++;
        assert (bus.level === e_lvl) else begin
            errors++; $error("FAIL %s level got %0d exp %0d", tag, bus.level, e_lvl);
        end
        checks++;
        assert (bus.top === e_top) else begin
            errors++; $error("FAIL %s top got %h exp %h", tag, bus.top, e_top);
        end
        checks++;
        assert (bus.empty === (m_stk.size() == 0) && bus.full === (m_stk.size() == D)) else begin
            errors++; $error("FAIL %s empty/full got %b/%b exp size %0d", tag, bus.empty, bus.full, m_stk.size());
        end
        checks++;
        assert (bus.overflow === m_ovf && bus.underflow === m_unf) else begin
            errors++; $error("FAIL %s ovf/unf got %b/%b exp %b/%b", tag, bus.overflow, bus.underflow, m_ovf, m_unf);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic ld, input logic ic,
                        input logic cl, input logic rt, input logic [W-1:0] a);
        reset    = r;
        bus.load = ld;
        bus.inc  = ic;
        bus.call = cl;
        bus.ret  = rt;
        bus.in   = a;
        @(posedge clock);
        model_step(r, ld, ic, cl, rt, a);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
        step("reset", 1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step("inc", 0, 0, 1, 0, 0, 16'h0);
        checks++;
        assert (bus.out === 16'd3) else begin
            errors++; $error("FAIL inc3 out got %h exp %h", bus.out, 16'd3);
        end

        step("load5", 0, 1, 0, 0, 0, 16'h0005);
        step("call100", 0, 0, 0, 1, 0, 16'h0100);
        checks++;
        assert (bus.top === 16'h0006) else begin
            errors++; $error("FAIL call_top got %h exp %h", bus.top, 16'h0006);
        end
        step("ret6", 0, 0, 0, 0, 1, 16'h0);

        step("load10", 0, 1, 0, 0, 0, 16'h0010);
        for (int i = 0; i < D; i++) step("nest_call", 0, 0, 0, 1, 0, W'(16'h20 + 16'h10 * i));
        step("call_full", 0, 0, 0, 1, 0, 16'hFFFF);
        for (int i = 0; i < D; i++) step("nest_ret", 0, 0, 0, 0, 1, 16'h0);
        checks++;
        assert (bus.out === 16'h0011) else begin
            errors++; $error("FAIL lifo_end out got %h exp %h", bus.out, 16'h0011);
        end

        step("ret_empty", 0, 0, 0, 0, 1, 16'h0);
        step("load42", 0, 1, 0, 0, 0, 16'h0042);
        step("hold", 0, 0, 0, 0, 0, 16'h1234);

        step("reset2", 1, 0, 0, 0, 0, 16'h0);
        step("loadFFFF", 0, 1, 0, 0, 0, 16'hFFFF);
        step("inc_wrap", 0, 0, 1, 0, 0, 16'h0);
        step("loadFFFF", 0, 1, 0, 0, 0, 16'hFFFF);
        step("call_wrap", 0, 0, 0, 1, 0, 16'h0001);
        checks++;
        assert (bus.top === 16'h0000) else begin
            errors++; $error("FAIL call_wrap top got %h exp %h", bus.top, 16'h0000);
        end

        step("reset3", 1, 0, 0, 0, 0, 16'h0);
        step("load3", 0, 1, 0, 0, 0, 16'h0003);
        step("call9", 0, 0, 0, 1, 0, 16'h0009);
        step("call60", 0, 0, 0, 1, 0, 16'h0060);
        step("prio", 0, 1, 1, 1, 1, 16'h0077);
        step("rst_call", 1, 0, 0, 1, 0, 16'h0055);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] s;
            s = 4'($urandom);
            step("rand", ($urandom_range(0, 31) == 0), s[0], s[1], s[2], s[3],
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
